// File: rtl/chemical_safety_responder.sv
// chemical_safety_responder
//   Debounces an alarm request into a latched, acknowledgeable alarm, and
//   debounces a vent-valve request into a valve latch that stays open for a
//   minimum hold time after the request drops. During an unacknowledged alarm
//   the valve is also forced open.
//
// Ports
//   clk          rising-edge clock for all state
//   rst_n        asynchronous active-low reset
//   alarm_req    alarm request level (synchronous to clk)
//   valve_req    vent-valve request level (synchronous to clk)
//   ack          operator acknowledge, sampled every cycle
//   siren        audible alarm drive (high only in ALARM)
//   valve_open   vent valve drive (valve latch OR state==ALARM)
//   alarm_active high in ALARM or ACKED
//   state        IDLE=0, PENDING=1, ALARM=2, ACKED=3
//   alarm_count  accepted alarms, saturating
module chemical_safety_responder #(
  parameter int DEB_CYCLES  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alarm_req,
  input  logic             valve_req,
  input  logic             ack,
  output logic             siren,
  output logic             valve_open,
  output logic             alarm_active,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] alarm_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ALARM   = 2'd2,
    ACKED   = 2'd3
  } state_t;

  // Debounce counters hold the number of high samples seen so far, so the
  // accepting edge is the one where the counter already equals DEB_CYCLES-1.
  localparam logic [7:0]       DEB_LAST  = 8'(DEB_CYCLES - 1);
  localparam logic [7:0]       HOLD_INIT = 8'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           st_q, st_nxt;
  logic [7:0]       adeb_q, adeb_nxt;
  logic [7:0]       vdeb_q, vdeb_nxt;
  logic [7:0]       hold_q, hold_nxt;
  logic             latch_q, latch_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             siren_q, vopen_q, active_q;

  // Alarm FSM next-state and event counter
  always_comb begin
    st_nxt   = st_q;
    adeb_nxt = adeb_q;
    cnt_nxt  = cnt_q;
    case (st_q)
      IDLE: begin
        if (alarm_req) begin
          if (DEB_CYCLES == 1) begin
            st_nxt   = ALARM;
            adeb_nxt = 8'd0;
          end else begin
            st_nxt   = PENDING;
            adeb_nxt = 8'd1;
          end
        end
      end
      PENDING: begin
        if (!alarm_req) begin
          st_nxt   = IDLE;
          adeb_nxt = 8'd0;
        end else if (adeb_q == DEB_LAST) begin
          st_nxt   = ALARM;
          adeb_nxt = 8'd0;
        end else begin
          adeb_nxt = adeb_q + 8'd1;
        end
      end
      // Latched: only ack leaves ALARM, regardless of alarm_req.
      ALARM: begin
        if (ack) st_nxt = ACKED;
      end
      ACKED: begin
        if (!alarm_req) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
    if ((st_nxt == ALARM) && (st_q != ALARM) && (cnt_q != CNT_MAX))
      cnt_nxt = cnt_q + CNT_ONE;
  end

  // Valve debounce and hold. hold_q==0 while latched means "not holding";
  // the first low sample loads the counter, later low samples count it down.
  always_comb begin
    latch_nxt = latch_q;
    vdeb_nxt  = vdeb_q;
    hold_nxt  = hold_q;
    if (!latch_q) begin
      if (valve_req) begin
        if (vdeb_q == DEB_LAST) begin
          latch_nxt = 1'b1;
          vdeb_nxt  = 8'd0;
        end else begin
          vdeb_nxt = vdeb_q + 8'd1;
        end
      end else begin
        vdeb_nxt = 8'd0;
      end
    end else if (valve_req) begin
      hold_nxt = 8'd0;
    end else if (hold_q == 8'd0) begin
      hold_nxt = HOLD_INIT;
    end else if (hold_q == 8'd1) begin
      hold_nxt  = 8'd0;
      latch_nxt = 1'b0;
    end else begin
      hold_nxt = hold_q - 8'd1;
    end
  end

  // State and output registers; outputs are registered from next-state values
  // so they change coincident with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= IDLE;
      adeb_q   <= 8'd0;
      vdeb_q   <= 8'd0;
      hold_q   <= 8'd0;
      latch_q  <= 1'b0;
      cnt_q    <= '0;
      siren_q  <= 1'b0;
      vopen_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      st_q     <= st_nxt;
      adeb_q   <= adeb_nxt;
      vdeb_q   <= vdeb_nxt;
      hold_q   <= hold_nxt;
      latch_q  <= latch_nxt;
      cnt_q    <= cnt_nxt;
      siren_q  <= (st_nxt == ALARM);
      vopen_q  <= latch_nxt | (st_nxt == ALARM);
      active_q <= (st_nxt == ALARM) || (st_nxt == ACKED);
    end
  end

  assign state        = st_q;
  assign siren        = siren_q;
  assign valve_open   = vopen_q;
  assign alarm_active = active_q;
  assign alarm_count  = cnt_q;

endmodule

// File: tb/tb_chemical_safety_responder.sv
// Self-checking bench for chemical_safety_responder. Two instances share the
// inputs: u0 with defaults (DEB=4, HOLD=16, CNT_W=8) and u1 with DEB=1,
// HOLD=3, CNT_W=2. A behavioural model tracks consecutive-sample run lengths.
module tb_chemical_safety_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic alarm_req = 1'b0, valve_req = 1'b0, ack = 1'b0;

  logic       siren0, vopen0, active0;
  logic [1:0] state0;
  logic [7:0] count0;
  logic       siren1, vopen1, active1;
  logic [1:0] state1;
  logic [1:0] count1;

  chemical_safety_responder u0 (
    .clk(clk), .rst_n(rst_n), .alarm_req(alarm_req), .valve_req(valve_req), .ack(ack),
    .siren(siren0), .valve_open(vopen0), .alarm_active(active0), .state(state0),
    .alarm_count(count0)
  );

  chemical_safety_responder #(.DEB_CYCLES(1), .HOLD_CYCLES(3), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .alarm_req(alarm_req), .valve_req(valve_req), .ack(ack),
    .siren(siren1), .valve_open(vopen1), .alarm_active(active1), .state(state1),
    .alarm_count(count1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: st 0..3, run = consecutive alarm_req highs while idle/pending,
  // vrun = consecutive valve_req highs while unlatched, low = consecutive lows
  // while latched (latch drops after HOLD+1 lows).
  int m_st[2], m_run[2], m_cnt[2], m_vrun[2], m_low[2];
  bit m_latch[2];
  int deb_p[2]  = '{4, 1};
  int hold_p[2] = '{16, 3};
  int cmax_p[2] = '{255, 3};

  logic [12:0] obs0, obs1;
  assign obs0 = {state0, siren0, vopen0, active0, count0};
  assign obs1 = {state1, siren1, vopen1, active1, 6'b0, count1};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_run[i] = 0; m_cnt[i] = 0;
      m_vrun[i] = 0; m_low[i] = 0; m_latch[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_st[i] = 0; m_run[i] = 0; m_cnt[i] = 0;
        m_vrun[i] = 0; m_low[i] = 0; m_latch[i] = 1'b0;
        continue;
      end
      if (m_st[i] <= 1) begin
        m_run[i] = alarm_req ? m_run[i] + 1 : 0;
        if (m_run[i] >= deb_p[i]) begin
          m_st[i] = 2;
          m_run[i] = 0;
          if (m_cnt[i] < cmax_p[i]) m_cnt[i]++;
        end else begin
          m_st[i] = (m_run[i] > 0) ? 1 : 0;
        end
      end else if (m_st[i] == 2) begin
        if (ack) m_st[i] = 3;
      end else begin
        if (!alarm_req) m_st[i] = 0;
      end
      if (!m_latch[i]) begin
        m_vrun[i] = valve_req ? m_vrun[i] + 1 : 0;
        if (m_vrun[i] >= deb_p[i]) begin
          m_latch[i] = 1'b1;
          m_vrun[i] = 0;
          m_low[i] = 0;
        end
      end else begin
        m_low[i] = valve_req ? 0 : m_low[i] + 1;
        if (m_low[i] == hold_p[i] + 1) begin
          m_latch[i] = 1'b0;
          m_low[i] = 0;
        end
      end
    end
  endtask

  function automatic logic [12:0] expv(int i);
    logic [1:0] s;
    logic [7:0] c;
    s = 2'(m_st[i]);
    c = 8'(m_cnt[i]);
    return {s, (m_st[i] == 2), (m_latch[i] || m_st[i] == 2), (m_st[i] >= 2), c};
  endfunction

  task automatic cycle(input bit a, input bit v, input bit k);
    alarm_req = a;
    valve_req = v;
    ack = k;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic settle();
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    for (int n = 0; n < 20; n++) cycle(0, 0, 0);
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs0 !== 13'h0) begin errors++; $display("FAIL reset_u0 got %h want %h", obs0, 13'h0); end
    checks++;
    if (obs1 !== 13'h0) begin errors++; $display("FAIL reset_u1 got %h want %h", obs1, 13'h0); end
    cycle(1, 1, 1);
    checks++;
    if (obs0 !== 13'h0) begin errors++; $display("FAIL reset_held_u0 got %h want %h", obs0, 13'h0); end
    checks++;
    if (obs1 !== 13'h0) begin errors++; $display("FAIL reset_held_u1 got %h want %h", obs1, 13'h0); end
    rst_n = 1'b1;
  endtask

  task automatic test_alarm_sequence();
    logic [1:0] st_tbl[4];
    st_tbl = '{2'd1, 2'd1, 2'd1, 2'd2};
    for (int e = 0; e < 4; e++) begin
      cycle(1, 0, 0);
      checks++;
      if (state0 !== st_tbl[e]) begin errors++; $display("FAIL alarm_seq_state edge%0d got %0d want %0d", e + 1, state0, st_tbl[e]); end
      checks++;
      if (obs1 !== expv(1)) begin errors++; $display("FAIL alarm_seq_u1 edge%0d got %h want %h", e + 1, obs1, expv(1)); end
    end
    checks++;
    if (siren0 !== 1'b1 || count0 !== 8'd1) begin errors++; $display("FAIL alarm_seq_siren_count got %b/%0d want 1/1", siren0, count0); end
    cycle(1, 0, 1);
    checks++;
    if (state0 !== 2'd3 || siren0 !== 1'b0 || active0 !== 1'b1) begin errors++; $display("FAIL alarm_seq_ack got %0d/%b/%b want 3/0/1", state0, siren0, active0); end
    cycle(1, 0, 1);
    checks++;
    if (obs0 !== expv(0)) begin errors++; $display("FAIL alarm_seq_acked_hold got %h want %h", obs0, expv(0)); end
    cycle(0, 0, 0);
    checks++;
    if (state0 !== 2'd0 || active0 !== 1'b0) begin errors++; $display("FAIL alarm_seq_clear got %0d/%b want 0/0", state0, active0); end
    checks++;
    if (obs1 !== expv(1)) begin errors++; $display("FAIL alarm_seq_clear_u1 got %h want %h", obs1, expv(1)); end
  endtask

  task automatic test_short_pulse();
    logic [1:0] st_tbl[4];
    logic [7:0] c_before;
    st_tbl = '{2'd1, 2'd1, 2'd1, 2'd0};
    settle();
    c_before = count0;
    for (int e = 0; e < 4; e++) begin
      cycle(e < 3, 0, 0);
      checks++;
      if (state0 !== st_tbl[e] || siren0 !== 1'b0 || count0 !== c_before) begin
        errors++;
        $display("FAIL short_pulse edge%0d got st=%0d siren=%b cnt=%0d want st=%0d siren=0 cnt=%0d",
                 e + 1, state0, siren0, count0, st_tbl[e], c_before);
      end
      checks++;
      if (obs1 !== expv(1)) begin errors++; $display("FAIL short_pulse_u1 edge%0d got %h want %h", e + 1, obs1, expv(1)); end
    end
  endtask

  task automatic test_latched();
    settle();
    for (int e = 0; e < 4; e++) cycle(1, 0, 0);
    for (int e = 0; e < 24; e++) begin
      cycle(0, 0, 0);
      checks++;
      if (state0 !== 2'd2 || siren0 !== 1'b1 || vopen0 !== 1'b1) begin
        errors++;
        $display("FAIL latched cyc%0d got st=%0d siren=%b valve=%b want 2/1/1", e, state0, siren0, vopen0);
      end
    end
    cycle(0, 0, 1);
    checks++;
    if (obs0 !== expv(0) || vopen0 !== 1'b0) begin errors++; $display("FAIL latched_ack got %h want %h", obs0, expv(0)); end
    checks++;
    if (obs1 !== expv(1)) begin errors++; $display("FAIL latched_ack_u1 got %h want %h", obs1, expv(1)); end
  endtask

  task automatic test_valve_hold();
    settle();
    // Open from edge 4 through edge 20, closed at edge 21.
    for (int e = 1; e <= 24; e++) begin
      cycle(0, e <= 4, 0);
      checks++;
      if (vopen0 !== ((e >= 4) && (e <= 20))) begin
        errors++;
        $display("FAIL valve_hold edge%0d got %b want %b", e, vopen0, ((e >= 4) && (e <= 20)));
      end
      checks++;
      if (obs1 !== expv(1)) begin errors++; $display("FAIL valve_hold_u1 edge%0d got %h want %h", e, obs1, expv(1)); end
    end
    // Reassert at hold cycle 10: valve must stay open without a gap.
    for (int e = 1; e <= 4; e++) cycle(0, 1, 0);
    for (int e = 1; e <= 40; e++) begin
      cycle(0, (e >= 10 && e <= 12), 0);
      checks++;
      if (vopen0 !== ((e <= 28) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL valve_reassert cyc%0d got %b want %b", e, vopen0, ((e <= 28) ? 1'b1 : 1'b0));
      end
    end
  endtask

  task automatic test_count_saturation();
    logic [1:0] tbl[5];
    tbl = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst_n = 1'b0;
    model_reset();
    cycle(0, 0, 0);
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      for (int e = 0; e < 4; e++) cycle(1, 0, 0);
      checks++;
      if (count1 !== tbl[n]) begin errors++; $display("FAIL count_sat_u1 seq%0d got %0d want %0d", n, count1, tbl[n]); end
      checks++;
      if (count0 !== 8'(n + 1)) begin errors++; $display("FAIL count_u0 seq%0d got %0d want %0d", n, count0, n + 1); end
      cycle(1, 0, 1);
      cycle(0, 0, 0);
      checks++;
      if (obs0 !== expv(0) || obs1 !== expv(1)) begin
        errors++;
        $display("FAIL count_seq_clear seq%0d got %h/%h want %h/%h", n, obs0, obs1, expv(0), expv(1));
      end
    end
  endtask

  task automatic test_random();
    bit a, v;
    a = 1'b0;
    v = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 99) >= 85) a = ~a;
      if ($urandom_range(0, 99) >= 90) v = ~v;
      cycle(a, v, $urandom_range(0, 9) == 0);
      checks++;
      if (obs0 !== expv(0)) begin errors++; $display("FAIL random_u0 cyc%0d got %h want %h", n, obs0, expv(0)); end
      checks++;
      if (obs1 !== expv(1)) begin errors++; $display("FAIL random_u1 cyc%0d got %h want %h", n, obs1, expv(1)); end
    end
  endtask

  task automatic test_async_reset();
    settle();
    for (int e = 0; e < 4; e++) cycle(1, 1, 0);
    checks++;
    if (state0 !== 2'd2 || vopen0 !== 1'b1) begin errors++; $display("FAIL async_setup got st=%0d valve=%b want 2/1", state0, vopen0); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs0 !== 13'h0) begin errors++; $display("FAIL async_reset_u0 got %h want %h", obs0, 13'h0); end
    checks++;
    if (obs1 !== 13'h0) begin errors++; $display("FAIL async_reset_u1 got %h want %h", obs1, 13'h0); end
    #3;
    rst_n = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      cycle(1, 0, 0);
      checks++;
      if (state0 !== ((e < 4) ? 2'd1 : 2'd2)) begin
        errors++;
        $display("FAIL async_redebounce edge%0d got %0d want %0d", e, state0, ((e < 4) ? 2'd1 : 2'd2));
      end
      checks++;
      if (obs0 !== expv(0) || obs1 !== expv(1)) begin
        errors++;
        $display("FAIL async_redebounce_all edge%0d got %h/%h want %h/%h", e, obs0, obs1, expv(0), expv(1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_alarm_sequence();
    test_short_pulse();
    test_latched();
    test_valve_hold();
    test_count_saturation();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chemical_safety_responder.md
CHEMICAL_SAFETY_RESPONDER -- requirements
Module: chemical_safety_responder

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 4, consecutive cycles a request must be held before it is accepted (range 1..255).
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 16, minimum cycles the valve stays open after valve_req drops (range 1..255).
REQ-003 The block SHALL have parameter CNT_W, default 8, width of the alarm event counter.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low; ports are named clk and rst_n.
REQ-005 The block SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-006 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port alarm_req, input, 1, alarm request from the safety logic (A), level.
REQ-008 The block SHALL have port valve_req, input, 1, vent-valve request from the safety logic (V), level.
REQ-009 The block SHALL have port ack, input, 1, operator acknowledge, sampled per cycle.
REQ-010 The block SHALL have port siren, output, 1, audible alarm drive.
REQ-011 The block SHALL have port valve_open, output, 1, vent valve drive.
REQ-012 The block SHALL have port alarm_active, output, 1, high in ALARM or ACKED.
REQ-013 The block SHALL have port state, output, 2, encoding IDLE=0, PENDING=1, ALARM=2, ACKED=3.
REQ-014 The block SHALL have port alarm_count, output, CNT_W, number of accepted alarms.

Function
REQ-015 All outputs SHALL be decoded only from registers, glitch-free; inputs SHALL be assumed synchronous to clk.
REQ-016 IDLE: on alarm_req=1 go to PENDING with debounce count=1; otherwise stay.
REQ-017 PENDING: alarm_req=0 SHALL return to IDLE and clear the count; alarm_req=1 SHALL increment the count, entering ALARM on the edge where the count would reach DEB_CYCLES (alarm_req sampled high on DEB_CYCLES consecutive edges).
REQ-018 DEB_CYCLES=1 SHALL take IDLE directly to ALARM on the first sampled alarm_req=1.
REQ-019 ALARM: siren=1, alarm_active=1; ack=1 SHALL go to ACKED; alarm_req dropping without ack SHALL NOT leave ALARM (latched).
REQ-020 ACKED: siren=0, alarm_active=1; alarm_req=0 SHALL go to IDLE; alarm_req=1 SHALL stay.
REQ-021 ack SHALL be ignored in IDLE, PENDING and ACKED.
REQ-022 alarm_count SHALL increment by 1 on every entry into ALARM and saturate at 2^CNT_W-1.
REQ-023 Valve debounce: valve latch SHALL set after valve_req sampled high on DEB_CYCLES consecutive edges; any low sample before that SHALL clear the valve debounce count.
REQ-024 Once latched, valve_req=0 SHALL load a hold counter with HOLD_CYCLES and decrement it each cycle valve_req stays 0; the latch SHALL clear on the edge the counter reaches 0.
REQ-025 valve_req=1 during hold SHALL abort the hold and keep the latch set without re-debounce.
REQ-026 valve_open SHALL equal valve latch OR (state==ALARM) (fail-safe venting during unacknowledged alarm).
REQ-027 Alarm FSM and valve logic SHALL be independent; simultaneous events in one cycle SHALL each be applied.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, siren=0, valve_open=0, alarm_active=0, alarm_count=0, all debounce and hold counters 0, regardless of clock.
REQ-029 Reset mid-operation (any state, during hold) SHALL abandon it; after release, requests SHALL be re-debounced from zero.

Verification
REQ-030 alarm_req 0->1 held: state 1 after edge 1, siren=1 and alarm_count=1 after edge 4; ack pulse -> state=3, siren=0; alarm_req=0 -> state=0.
REQ-031 alarm_req high 3 cycles then low: state 0->1->1->1->0, siren never 1, alarm_count stays 0.
REQ-032 alarm_req pulse accepted then dropped with no ack: state stays 2, siren=1, valve_open=1 indefinitely until ack.
REQ-033 valve_req high 4 cycles then low: valve_open=1 from edge 4, stays 1 for 16 more cycles, then 0; reassert at hold cycle 10 keeps valve_open=1 continuously.
REQ-034 CNT_W=2, five accepted alarm/ack/clear sequences: alarm_count reads 1,2,3,3,3.
REQ-035 rst_n pulled low asynchronously while in ALARM with valve latched: all outputs 0 before next clk edge; after release, alarm_req needs 4 fresh high samples to re-alarm.
